// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard-detection and forwarding controller for the pipelined CPU.
// In-flight register writers are tracked in a DEPTH-entry shift scoreboard;
// entry k is the instruction that left ID k cycles ago. Each entry carries
// valid, destination register and result latency. An entry is "ready"
// (its result sits on forward bus k) once k >= latency.
//
// For the instruction currently in ID the block picks, per source operand,
// the youngest matching writer. If that writer is ready, its bus is selected.
// If it is not ready, PC and IF/ID are stalled and a bubble enters EX.
// A saturating counter records stall cycles for performance measurement.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   id_valid_i   ID holds a real instruction
//   rs_i, rt_i   ID source registers
//   use_rs_i     ID instruction reads rs
//   use_rt_i     ID instruction reads rt
//   id_wen_i     ID instruction writes a register
//   id_rd_i      ID destination register
//   id_lat_i     stages until the ID result reaches a forward bus
//   flush_i      kill the instruction in ID
//   freeze_i     global pipeline hold; scoreboard and counter keep state
//   stall_o      hold PC and IF/ID, insert a bubble into EX
//   fwd_rs_o     rs source: 0 = register file, k = result bus of stage k
//   fwd_rt_o     rt source, same encoding
//   stall_cnt_o  saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [REG_AW-1:0]          rs_i,
  input  logic [REG_AW-1:0]          rt_i,
  input  logic                       use_rs_i,
  input  logic                       use_rt_i,
  input  logic                       id_wen_i,
  input  logic [REG_AW-1:0]          id_rd_i,
  input  logic [LAT_W-1:0]           id_lat_i,
  input  logic                       flush_i,
  input  logic                       freeze_i,
  output logic                       stall_o,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs_o,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rt_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             hit;
    logic             ready;
    logic [SEL_W-1:0] stage;
  } match_t;

  // Scoreboard state, index k = stages past ID.
  logic [DEPTH:1]    valid_q, valid_d;
  logic [REG_AW-1:0] rd_q  [1:DEPTH];
  logic [REG_AW-1:0] rd_d  [1:DEPTH];
  logic [SEL_W-1:0]  lat_q [1:DEPTH];
  logic [SEL_W-1:0]  lat_d [1:DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  match_t rs_m, rt_m;

  // Latency 0 behaves like 1; anything deeper than the scoreboard is
  // ready at the last tracked stage.
  function automatic logic [SEL_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    int v;
    v = int'(lat);
    if (v < 1)          v = 1;
    else if (v > DEPTH) v = DEPTH;
    return SEL_W'(v);
  endfunction

  // Youngest-match search: scanning from the oldest stage down lets the
  // lowest matching k overwrite any older match.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no
    // latch is inferred.
    rs_m = '0;
    rt_m = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_rs_i && rs_i != '0 && valid_q[k] && rd_q[k] == rs_i) begin
        rs_m.hit   = 1'b1;
        rs_m.ready = (int'(lat_q[k]) <= k);
        rs_m.stage = SEL_W'(k);
      end
      if (use_rt_i && rt_i != '0 && valid_q[k] && rd_q[k] == rt_i) begin
        rt_m.hit   = 1'b1;
        rt_m.ready = (int'(lat_q[k]) <= k);
        rt_m.stage = SEL_W'(k);
      end
    end
  end

  assign stall_o  = id_valid_i & ~flush_i &
                    ((rs_m.hit & ~rs_m.ready) | (rt_m.hit & ~rt_m.ready));
  assign fwd_rs_o = (rs_m.hit && rs_m.ready) ? rs_m.stage : '0;
  assign fwd_rt_o = (rt_m.hit && rt_m.ready) ? rt_m.stage : '0;
  assign stall_cnt_o = cnt_q;

  // Next state. The producer keeps advancing during a stall; only the ID
  // instruction is held back, replaced in stage 1 by a bubble.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    if (!freeze_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        lat_d[k]   = lat_q[k-1];
      end
      valid_d[1] = id_valid_i & id_wen_i & (id_rd_i != '0) & ~stall_o & ~flush_i;
      rd_d[1]    = id_rd_i;
      lat_d[1]   = clamp_lat(id_lat_i);
      if (stall_o && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      cnt_q   <= '0;
      // NOTE: rd/lat are qualified by valid and need no reset functionally;
      // they are cleared anyway so the small array never carries X.
      for (int k = 1; k <= DEPTH; k++) begin
        rd_q[k]  <= '0;
        lat_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      valid_q <= valid_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed stimulus with hand-computed expectations. Each stimulus step pushes
// its expected outputs into a queue; a monitor pops and compares on the
// falling edge, away from the active rising edge. A second instance with a
// 2-bit counter shares the inputs and exercises counter saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid, use_rs, use_rt, id_wen, flush, freeze;
  logic [4:0] rs, rt, id_rd;
  logic [1:0] id_lat;

  logic        stall,  stall2;
  logic [1:0]  fwd_rs, fwd_rt, fwd_rs2, fwd_rt2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LAT_W(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .rs_i(rs), .rt_i(rt),
    .use_rs_i(use_rs), .use_rt_i(use_rt), .id_wen_i(id_wen), .id_rd_i(id_rd),
    .id_lat_i(id_lat), .flush_i(flush), .freeze_i(freeze), .stall_o(stall),
    .fwd_rs_o(fwd_rs), .fwd_rt_o(fwd_rt), .stall_cnt_o(cnt)
  );

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LAT_W(2), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .rs_i(rs), .rt_i(rt),
    .use_rs_i(use_rs), .use_rt_i(use_rt), .id_wen_i(id_wen), .id_rd_i(id_rd),
    .id_lat_i(id_lat), .flush_i(flush), .freeze_i(freeze), .stall_o(stall2),
    .fwd_rs_o(fwd_rs2), .fwd_rt_o(fwd_rt2), .stall_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected stall counters: incremented when a step expects a stall on an
  // unfrozen edge, cleared by reset; the narrow one saturates at 3.
  logic [15:0] m_cnt  = '0;
  logic [1:0]  m_cnt2 = '0;

  task automatic check(input string name, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, what, act, exp);
    end
  endtask

  // Monitor: the combinational outputs are presented every cycle; compare
  // whatever expectations are pending at each falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, "stall",    int'(stall),   int'(e.stall));
      check(e.name, "fwd_rs",   int'(fwd_rs),  int'(e.frs));
      check(e.name, "fwd_rt",   int'(fwd_rt),  int'(e.frt));
      check(e.name, "cnt",      int'(cnt),     int'(e.cnt));
      check(e.name, "stall_s",  int'(stall2),  int'(e.stall));
      check(e.name, "fwd_rs_s", int'(fwd_rs2), int'(e.frs));
      check(e.name, "fwd_rt_s", int'(fwd_rt2), int'(e.frt));
      check(e.name, "cnt_sat",  int'(cnt2),    int'(e.cnt2));
    end
  end

  task automatic drv(input logic v, input logic [4:0] s, input logic [4:0] t,
                     input logic us, input logic ut, input logic w,
                     input logic [4:0] d, input logic [1:0] l,
                     input logic fl, input logic fz);
    id_valid = v; rs = s; rt = t; use_rs = us; use_rt = ut;
    id_wen = w; id_rd = d; id_lat = l; flush = fl; freeze = fz;
  endtask

  // Push the expectation for the current inputs, let the monitor compare it,
  // then take one rising edge and return 1 ns after it.
  task automatic step(input string name, input logic est,
                      input logic [1:0] efrs, input logic [1:0] efrt);
    exp_t e;
    e.name = name; e.stall = est; e.frs = efrs; e.frt = efrt;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    if (est && !freeze && !rst) begin
      m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
    #1;
  endtask

  task automatic idle(input string name);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(name, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    idle("reset_state");

    // ALU chain: forward from stage 1, 2, 3, then register file
    drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step("alu_issue", 0, 0, 0);
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); step("alu_fwd1", 0, 1, 0);
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); step("alu_fwd2", 0, 2, 0);
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); step("alu_fwd3", 0, 3, 0);
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); step("alu_retired", 0, 0, 0);

    // Load-use: one stall cycle, then forward from stage 2
    drv(1, 0, 0, 0, 0, 1, 8, 2, 0, 0); step("ld_issue", 0, 0, 0);
    drv(1, 0, 8, 0, 1, 0, 0, 0, 0, 0); step("ld_use_stall", 1, 0, 0);
    drv(1, 0, 8, 0, 1, 0, 0, 0, 0, 0); step("ld_use_fwd2", 0, 0, 2);
    idle("ld_after");

    // Priority: youngest writer wins, ready or not
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); step("pri_w_old", 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); step("pri_w_new", 0, 0, 0);
    drv(1, 3, 3, 1, 1, 0, 0, 0, 0, 0); step("pri_both1", 0, 1, 1);
    drv(1, 0, 0, 0, 0, 1, 3, 2, 0, 0); step("pri_w_load", 0, 0, 0);
    drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); step("pri_young_notready", 1, 0, 0);
    drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); step("pri_young_fwd2", 0, 2, 0);
    idle("pri_after");

    // Zero register and use flags
    drv(1, 0, 0, 0, 0, 1, 0, 2, 0, 0); step("zero_issue", 0, 0, 0);
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); step("zero_read", 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 7, 2, 0, 0); step("nouse_issue", 0, 0, 0);
    drv(1, 0, 7, 0, 0, 0, 0, 0, 0, 0); step("nouse_read", 0, 0, 0);

    // Latency 0 behaves as 1; latency 3 stalls twice
    drv(1, 0, 0, 0, 0, 1, 10, 0, 0, 0); step("lat0_issue", 0, 0, 0);
    drv(1, 10, 0, 1, 0, 0, 0, 0, 0, 0); step("lat0_fwd1", 0, 1, 0);
    drv(1, 0, 0, 0, 0, 1, 11, 3, 0, 0); step("lat3_issue", 0, 0, 0);
    drv(1, 11, 0, 1, 0, 0, 0, 0, 0, 0); step("lat3_stall_a", 1, 0, 0);
    drv(1, 11, 0, 1, 0, 0, 0, 0, 0, 0); step("lat3_stall_b", 1, 0, 0);
    drv(1, 11, 0, 1, 0, 0, 0, 0, 0, 0); step("lat3_fwd3", 0, 3, 0);

    // Freeze during a load-use stall: state and counter hold
    drv(1, 0, 0, 0, 0, 1, 9, 2, 0, 0); step("frz_issue", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 9, 0, 1, 0, 0, 0, 0, 1); step($sformatf("frz_hold%0d", i), 1, 0, 0);
    end
    drv(1, 0, 9, 0, 1, 0, 0, 0, 0, 0); step("frz_release", 1, 0, 0);
    drv(1, 0, 9, 0, 1, 0, 0, 0, 0, 0); step("frz_fwd2", 0, 0, 2);

    // Flush: flushed writer leaves a bubble; flushed consumer does not stall
    drv(1, 0, 0, 0, 0, 1, 12, 2, 1, 0); step("fl_writer", 0, 0, 0);
    drv(1, 0, 12, 0, 1, 0, 0, 0, 0, 0); step("fl_no_hazard", 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 13, 2, 0, 0); step("fl_ld_issue", 0, 0, 0);
    drv(1, 13, 0, 1, 0, 0, 0, 0, 1, 0); step("fl_consumer", 0, 0, 0);
    drv(1, 13, 0, 1, 0, 0, 0, 0, 0, 0); step("fl_fwd2", 0, 2, 0);

    // Asynchronous reset with three valid entries
    drv(1, 0, 0, 0, 0, 1, 14, 1, 0, 0); step("rst_w14", 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 15, 2, 0, 0); step("rst_w15", 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 16, 2, 0, 0); step("rst_w16", 0, 0, 0);
    drv(1, 16, 15, 1, 1, 0, 0, 0, 0, 1); step("rst_pre", 1, 0, 2);
    rst = 1'b1;
    m_cnt = '0;
    m_cnt2 = '0;
    step("rst_async", 0, 0, 0);
    rst = 1'b0;
    step("rst_released", 0, 0, 0);
    idle("rst_idle");

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
